counter_updown_mod: RTL and testbench

- Parametrised up/down counter with programmable terminal value and selectable end-of-range mode: wrap, saturate or one-shot.
- Next-generation general counter for timers, prescalers and address generators.
- Adds asynchronous reset, load clamping, a registered wrap pulse, a one-shot done flag and a cascade carry.

---
 rtl/counter_pkg.sv | 24 ++
 rtl/counter_updown_mod.sv | 80 ++++++++
 tb/tb_counter_updown_mod.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter: end-of-range mode encodings
// and the clamp helper used when loading a new value.
package counter_pkg;

  localparam int unsigned MODE_W    = 2;
  localparam int unsigned CLAMP_W   = 32;

  localparam logic [MODE_W-1:0] MODE_WRAP    = 2'b00;
  localparam logic [MODE_W-1:0] MODE_SAT     = 2'b01;
  localparam logic [MODE_W-1:0] MODE_ONESHOT = 2'b10;
  localparam logic [MODE_W-1:0] MODE_RSVD    = 2'b11;

  // Saturating clamp of a load value against the terminal count.
  function automatic logic [CLAMP_W-1:0] clamp_to(input logic [CLAMP_W-1:0] value,
                                                  input logic [CLAMP_W-1:0] limit);
    return (value > limit) ? limit : value;
  endfunction

  // Reserved encoding behaves as wrap.
  function automatic logic is_wrap_mode(input logic [MODE_W-1:0] mode);
    return (mode == MODE_WRAP) || (mode == MODE_RSVD);
  endfunction

endpackage

// File: rtl/counter_updown_mod.sv
// Parametrised up/down counter with wrap / saturate / one-shot end-of-range
// behaviour, clamped load, registered wrap pulse, sticky done and cascade carry.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH       = 10,
  parameter logic [WIDTH-1:0] MAX_VALUE   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             en,
  input  logic             load,
  input  logic             updown,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] counter_value,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap_pulse,
  output logic             done,
  output logic             carry_out
);

  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q_nxt;
  logic             done_nxt;
  logic             wrap_pulse_nxt;
  logic             wrap_sel;
  logic             sat_sel;
  logic             oneshot_sel;

  // Terminal value depends on direction; tc tracks updown without a clock.
  assign term        = updown ? '0 : MAX_VALUE;
  assign tc          = (q == term);
  assign wrap_sel    = is_wrap_mode(mode);
  assign sat_sel     = (mode == MODE_SAT);
  assign oneshot_sel = (mode == MODE_ONESHOT);
  assign load_val    = WIDTH'(clamp_to(CLAMP_W'(counter_value), CLAMP_W'(MAX_VALUE)));
  assign carry_out   = ce & en & ~load & tc & wrap_sel;

  // Next-state: load beats count; counting at term follows the selected mode.
  always_comb begin
    q_nxt          = q;
    done_nxt       = done;
    wrap_pulse_nxt = wrap_pulse;
    if (ce) begin
      wrap_pulse_nxt = 1'b0;
      if (load) begin
        q_nxt    = load_val;
        done_nxt = 1'b0;
      end else if (en && !(oneshot_sel && done)) begin
        if (!tc) begin
          q_nxt = updown ? (q - WIDTH'(1)) : (q + WIDTH'(1));
        end else if (sat_sel) begin
          q_nxt = q;
        end else if (oneshot_sel) begin
          done_nxt = 1'b1;
        end else begin
          q_nxt          = updown ? MAX_VALUE : '0;
          wrap_pulse_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q          <= RESET_VALUE;
      done       <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      q          <= q_nxt;
      done       <= done_nxt;
      wrap_pulse <= wrap_pulse_nxt;
    end
  end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Scoreboard bench for counter_updown_mod: a single WIDTH=4/MAX=9 counter plus a
// two-stage decimal cascade, checked against a behavioural model.
module tb_counter_updown_mod;

  localparam int MAXV = 9;
  localparam int RSTV = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ce = 1'b0, en = 1'b0, load = 1'b0, updown = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] counter_value = 4'd0;
  logic [3:0] q;
  logic       tc, wrap_pulse, done, carry_out;

  logic       c_en = 1'b0;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, lo_wp, lo_done, lo_carry;
  logic       hi_tc, hi_wp, hi_done, hi_carry;

  always #5 clk = ~clk;

  counter_updown_mod #(.WIDTH(4), .MAX_VALUE(4'd9), .RESET_VALUE(4'd3)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .en(en), .load(load), .updown(updown),
    .mode(mode), .counter_value(counter_value), .q(q), .tc(tc),
    .wrap_pulse(wrap_pulse), .done(done), .carry_out(carry_out)
  );

  counter_updown_mod #(.WIDTH(4), .MAX_VALUE(4'd9), .RESET_VALUE(4'd0)) lo (
    .clk(clk), .rst_n(rst_n), .ce(1'b1), .en(c_en), .load(1'b0), .updown(1'b0),
    .mode(2'b00), .counter_value(4'd0), .q(lo_q), .tc(lo_tc),
    .wrap_pulse(lo_wp), .done(lo_done), .carry_out(lo_carry)
  );

  counter_updown_mod #(.WIDTH(4), .MAX_VALUE(4'd9), .RESET_VALUE(4'd0)) hi (
    .clk(clk), .rst_n(rst_n), .ce(1'b1), .en(lo_carry), .load(1'b0), .updown(1'b0),
    .mode(2'b00), .counter_value(4'd0), .q(hi_q), .tc(hi_tc),
    .wrap_pulse(hi_wp), .done(hi_done), .carry_out(hi_carry)
  );

  typedef struct {
    int q;
    int done;
    int wp;
    int tc;
    int carry;
    int casc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passed = 0;

  // Reference state
  int mq = RSTV, mdone = 0, mwp = 0, ccount = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model of one qualifying clock edge.
  task automatic model_step(input bit i_ce, input bit i_en, input bit i_load,
                            input bit i_ud, input int i_mode, input int i_val);
    int term;
    if (!i_ce) return;
    mwp = 0;
    term = i_ud ? 0 : MAXV;
    if (i_load) begin
      mq    = (i_val > MAXV) ? MAXV : i_val;
      mdone = 0;
    end else if (i_en) begin
      if (i_mode == 2 && mdone == 1) begin
        // one-shot finished: frozen until load
      end else if (mq != term) begin
        mq = i_ud ? mq - 1 : mq + 1;
      end else if (i_mode == 1) begin
        // saturate: hold
      end else if (i_mode == 2) begin
        mdone = 1;
      end else begin
        mq  = i_ud ? MAXV : 0;
        mwp = 1;
      end
    end
  endtask

  // Apply inputs for the next edge; record what the DUT must show this cycle.
  task automatic drive(input bit i_ce, input bit i_en, input bit i_load, input bit i_ud,
                       input int i_mode, input int i_val, input bit i_cen);
    exp_t e;
    @(posedge clk);
    #1;
    ce = i_ce; en = i_en; load = i_load; updown = i_ud;
    mode = 2'(i_mode); counter_value = 4'(i_val); c_en = i_cen;
    e.q     = mq;
    e.done  = mdone;
    e.wp    = mwp;
    e.tc    = (mq == (i_ud ? 0 : MAXV)) ? 1 : 0;
    e.carry = (i_ce && i_en && !i_load && e.tc == 1 && (i_mode == 0 || i_mode == 3)) ? 1 : 0;
    e.casc  = ccount;
    sbq.push_back(e);
    model_step(i_ce, i_en, i_load, i_ud, i_mode, i_val);
    if (i_cen) ccount = (ccount + 1) % 100;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    @(negedge clk);
    #1;
    ce = 1'b0; en = 1'b0; load = 1'b0; c_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset_q", int'(q), RSTV);
    check("reset_done", int'(done), 0);
    check("reset_wrap_pulse", int'(wrap_pulse), 0);
    check("reset_cascade", int'(hi_q) * 10 + int'(lo_q), 0);
    mq = RSTV; mdone = 0; mwp = 0; ccount = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: compare every presented cycle against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("q", int'(q), e.q);
        check("done", int'(done), e.done);
        check("wrap_pulse", int'(wrap_pulse), e.wp);
        check("tc", int'(tc), e.tc);
        check("carry_out", int'(carry_out), e.carry);
        check("cascade", int'(hi_q) * 10 + int'(lo_q), e.casc);
      end
    end
  end

  initial begin
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 1);
    // wrap up from 8 and down from 1
    drive(1, 0, 1, 0, 0, 8, 1);
    repeat (4) drive(1, 1, 0, 0, 0, 0, 1);
    drive(1, 0, 1, 1, 0, 1, 1);
    repeat (3) drive(1, 1, 0, 1, 0, 0, 1);
    // saturate up, then reverse
    drive(1, 0, 1, 0, 1, 8, 1);
    repeat (4) drive(1, 1, 0, 0, 1, 0, 1);
    repeat (2) drive(1, 1, 0, 1, 1, 0, 1);
    // one-shot down from 2, then sticky done across a mode change, then reload
    drive(1, 0, 1, 1, 2, 2, 1);
    repeat (8) drive(1, 1, 0, 1, 2, 0, 1);
    repeat (2) drive(1, 1, 0, 1, 0, 0, 1);
    drive(1, 1, 0, 1, 2, 0, 1);
    drive(1, 1, 1, 1, 2, 6, 1);
    drive(1, 0, 0, 1, 2, 0, 1);
    // clamp and load priority at terminal
    drive(1, 0, 1, 0, 0, 9, 1);
    drive(1, 1, 1, 0, 0, 15, 1);
    drive(1, 0, 0, 0, 0, 0, 1);
    // ce gating
    repeat (4) drive(0, 1, 1, 0, 0, 2, 1);
    // wrap then reset with the pulse pending
    drive(1, 1, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 1);
    do_reset();
    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
            ($urandom_range(0, 9) != 0));
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
